// File: rtl/mul_acc_unit.sv
// Multi-cycle multiply / multiply-accumulate unit with a 2W-bit HI/LO accumulator.
// Split partial-product multiplier, flush abort and a ready/data_ok handshake.
module mul_acc_unit #(
   parameter int WIDTH = 32,
   parameter int LAT   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [1:0]         op,
   input  logic               sign,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               interrupt,
   input  logic               acc_we,
   input  logic [2*WIDTH-1:0] acc_wdata,
   output logic               ready,
   output logic               data_ok,
   output logic [2*WIDTH-1:0] result,
   output logic [2*WIDTH-1:0] acc
);

   localparam int W  = WIDTH;
   localparam int H  = WIDTH / 2;
   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(LAT + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          data_ok_q, data_ok_d;
   logic [W2-1:0] result_q, result_d;
   logic [W2-1:0] acc_q, acc_d;

   logic [W-1:0]  pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
   logic [W-1:0]  pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;
   logic          neg_q;
   logic [1:0]    op_q;
   logic [W2-1:0] snap_q, snap_d;

   logic          accept;
   logic          a_neg, b_neg;
   logic [W-1:0]  am, bm;
   logic [W2-1:0] psum, prod_c, prod_fin, res_c;

   assign accept = (state_q == S_IDLE) & en & ~interrupt;
   assign a_neg  = sign & a[W-1];
   assign b_neg  = sign & b[W-1];
   assign am     = a_neg ? (~a + 1'b1) : a;
   assign bm     = b_neg ? (~b + 1'b1) : b;
   assign snap_d = acc_we ? acc_wdata : acc_q;

   // Stage 1: four half-width partial products from the magnitudes.
   assign pp_ll_d = {{H{1'b0}}, am[H-1:0]} * {{H{1'b0}}, bm[H-1:0]};
   assign pp_lh_d = {{H{1'b0}}, am[H-1:0]} * {{H{1'b0}}, bm[W-1:H]};
   assign pp_hl_d = {{H{1'b0}}, am[W-1:H]} * {{H{1'b0}}, bm[H-1:0]};
   assign pp_hh_d = {{H{1'b0}}, am[W-1:H]} * {{H{1'b0}}, bm[W-1:H]};

   always_ff @(posedge clk) begin
      if (rst) begin
         pp_ll_q <= '0;
         pp_lh_q <= '0;
         pp_hl_q <= '0;
         pp_hh_q <= '0;
         neg_q   <= 1'b0;
         op_q    <= 2'b00;
         snap_q  <= '0;
      end else if (accept) begin
         pp_ll_q <= pp_ll_d;
         pp_lh_q <= pp_lh_d;
         pp_hl_q <= pp_hl_d;
         pp_hh_q <= pp_hh_d;
         neg_q   <= a_neg ^ b_neg;
         op_q    <= op;
         snap_q  <= snap_d;
      end
   end

   // Stage 2: sum the partial products and restore the sign.
   assign psum = {pp_hh_q, pp_ll_q}
               + {{H{1'b0}}, pp_lh_q, {H{1'b0}}}
               + {{H{1'b0}}, pp_hl_q, {H{1'b0}}};
   assign prod_c = neg_q ? (~psum + 1'b1) : psum;

   generate
      if (LAT > 2) begin : g_dly
         logic [W2-1:0] dly_q [LAT-2];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < LAT - 2; k++) dly_q[k] <= '0;
            end else begin
               dly_q[0] <= prod_c;
               for (int k = 1; k < LAT - 2; k++) dly_q[k] <= dly_q[k-1];
            end
         end
         assign prod_fin = dly_q[LAT-3];
      end else begin : g_nodly
         assign prod_fin = prod_c;
      end
   endgenerate

   always_comb begin
      unique case (op_q)
         2'b01:   res_c = snap_q + prod_fin;
         2'b10:   res_c = snap_q - prod_fin;
         default: res_c = prod_fin;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_ok_d = 1'b0;
      result_d  = result_q;
      acc_d     = acc_q;
      unique case (state_q)
         S_IDLE: begin
            if (acc_we) acc_d = acc_wdata;
            if (accept) begin
               state_d = S_BUSY;
               cnt_d   = CW'(1);
            end
         end
         S_BUSY: begin
            // Once data_ok is up the result is committed; flush is moot.
            if (data_ok_q || interrupt) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(LAT - 1)) begin
               data_ok_d = 1'b1;
               result_d  = res_c;
               if (op_q == 2'b01 || op_q == 2'b10) acc_d = res_c;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         data_ok_q <= 1'b0;
         result_q  <= '0;
         acc_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_ok_q <= data_ok_d;
         result_q  <= result_d;
         acc_q     <= acc_d;
      end
   end

   assign ready   = (state_q == S_IDLE);
   assign data_ok = data_ok_q;
   assign result  = result_q;
   assign acc     = acc_q;

endmodule

// File: tb/tb_mul_acc_unit.sv
// Bench for mul_acc_unit: W=32/LAT=3 and W=16/LAT=2 run side by side,
// each against a cycle model plus hand-computed literals.
module tb_mul_acc_unit;

   logic clk;
   int   tests = 0;
   int   fails = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int W   = (g == 0) ? 32 : 16;
      localparam int LAT = (g == 0) ? 3 : 2;
      localparam int W2  = 2 * W;
      localparam logic [63:0] EXP_FF  = (W == 32) ?
         64'hFFFFFFFE00000001 : 64'h00000000FFFE0001;
      localparam logic [63:0] EXP_M21 = (W == 32) ?
         64'hFFFFFFFFFFFFFFEB : 64'h00000000FFFFFFEB;
      localparam logic [63:0] EXP_MIN = (W == 32) ?
         64'h4000000000000000 : 64'h0000000040000000;
      localparam logic [63:0] EXP_MS  = (W == 32) ?
         64'hFFFFFFFFFFFFFFEC : 64'h00000000FFFFFFEC;
      localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
      localparam logic [W-1:0] ONES = {W{1'b1}};

      logic          rst, en, sign, intr, acc_we;
      logic [1:0]    op;
      logic [W-1:0]  a, b;
      logic [W2-1:0] acc_wdata;
      logic          ready, data_ok;
      logic [W2-1:0] result, acc;
      logic          chk_on = 1'b0;
      logic          done = 1'b0;
      string         pfx = $sformatf("w%0d_", W);

      mul_acc_unit #(.WIDTH(W), .LAT(LAT)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .op        (op),
         .sign      (sign),
         .a         (a),
         .b         (b),
         .interrupt (intr),
         .acc_we    (acc_we),
         .acc_wdata (acc_wdata),
         .ready     (ready),
         .data_ok   (data_ok),
         .result    (result),
         .acc       (acc)
      );

      // Reference: full-width arithmetic product, modulo 2^(2W).
      function automatic logic [W2-1:0] ref_prod(input logic s,
         input logic [W-1:0] x, input logic [W-1:0] y);
         logic [W2-1:0] sx, sy;
         sx = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
         sy = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
         return sx * sy;
      endfunction

      bit            m_busy = 1'b0;
      int            m_age = 0;
      logic [1:0]    m_op = 2'b00;
      logic [W2-1:0] m_acc = '0, m_res = '0, m_pend = '0;
      logic [W2-1:0] m_snap, m_p;

      initial forever begin
         @(posedge clk);
         if (rst) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_acc  = '0;
            m_res  = '0;
         end else if (m_busy) begin
            if (m_age == LAT) m_busy = 1'b0;
            else if (intr) m_busy = 1'b0;
            else begin
               m_age++;
               if (m_age == LAT) begin
                  m_res = m_pend;
                  if (m_op == 2'd1 || m_op == 2'd2) m_acc = m_pend;
               end
            end
         end else begin
            m_snap = acc_we ? acc_wdata : m_acc;
            if (acc_we) m_acc = acc_wdata;
            if (en && !intr) begin
               m_p    = ref_prod(sign, a, b);
               m_pend = (op == 2'd1) ? m_snap + m_p :
                        (op == 2'd2) ? m_snap - m_p : m_p;
               m_op   = op;
               m_busy = 1'b1;
               m_age  = 1;
            end
         end
      end

      initial forever begin
         @(negedge clk);
         if (chk_on) begin
            check({pfx, "ready"}, 64'(ready), 64'(!m_busy));
            check({pfx, "data_ok"}, 64'(data_ok),
                  64'(m_busy && m_age == LAT));
            check({pfx, "result"}, 64'(result), 64'(m_res));
            check({pfx, "acc"}, 64'(acc), 64'(m_acc));
         end
      end

      task automatic go(input logic [1:0] o, input logic s,
                        input logic [W-1:0] x, input logic [W-1:0] y);
         int seen = 0;
         op = o; sign = s; a = x; b = y; en = 1'b1;
         @(posedge clk); #1;
         en = 1'b0; acc_we = 1'b0;
         a = W'($urandom); b = W'($urandom);
         for (int n = 1; n <= LAT + 2; n++) begin
            @(negedge clk);
            if (data_ok) begin
               seen = n;
               break;
            end
         end
         check({pfx, "latency"}, 64'(seen), 64'(LAT));
         @(posedge clk); #1;
      endtask

      initial begin
         int pulses;
         rst = 1'b1; en = 1'b0; op = 2'b00; sign = 1'b0;
         a = '0; b = '0; intr = 1'b0; acc_we = 1'b0; acc_wdata = '0;
         @(posedge clk); #1;
         chk_on = 1'b1;
         @(negedge clk);
         check({pfx, "rst_ready"}, 64'(ready), 64'd1);
         check({pfx, "rst_result"}, 64'(result), 64'd0);
         check({pfx, "rst_acc"}, 64'(acc), 64'd0);
         @(posedge clk); #1;
         rst = 1'b0;

         go(2'b00, 1'b0, ONES, ONES);
         check({pfx, "mult_ff"}, 64'(result), EXP_FF);
         check({pfx, "model_ff"}, 64'(m_res), EXP_FF);
         check({pfx, "mult_acc0"}, 64'(acc), 64'd0);

         go(2'b00, 1'b1, W'(-3), W'(7));
         check({pfx, "mult_m21"}, 64'(result), EXP_M21);
         go(2'b11, 1'b1, MINV, MINV);
         check({pfx, "mult_min"}, 64'(result), EXP_MIN);
         check({pfx, "model_min"}, 64'(m_res), EXP_MIN);

         acc_wdata = W2'(100); acc_we = 1'b1;
         @(posedge clk); #1;
         acc_we = 1'b0;
         go(2'b01, 1'b1, W'(-5), W'(4));
         check({pfx, "madd_res"}, 64'(result), 64'd80);
         check({pfx, "madd_acc"}, 64'(acc), 64'd80);
         go(2'b10, 1'b0, W'(10), W'(10));
         check({pfx, "msub_acc"}, 64'(acc), EXP_MS);
         check({pfx, "model_msub"}, 64'(m_acc), EXP_MS);

         acc_wdata = W2'(1000); acc_we = 1'b1;
         go(2'b01, 1'b0, W'(2), W'(3));
         check({pfx, "we_en_acc"}, 64'(acc), 64'd1006);

         acc_wdata = W2'(5); acc_we = 1'b1;
         @(posedge clk); #1;
         acc_we = 1'b0;
         op = 2'b01; sign = 1'b1; a = W'(3); b = W'(4); en = 1'b1;
         @(posedge clk); #1;
         en = 1'b0;
         repeat (LAT - 2) begin
            @(posedge clk); #1;
         end
         intr = 1'b1; acc_we = 1'b1; acc_wdata = W2'(77);
         @(posedge clk); #1;
         intr = 1'b0; acc_we = 1'b0;
         @(negedge clk);
         check({pfx, "flush_ready"}, 64'(ready), 64'd1);
         check({pfx, "flush_dok"}, 64'(data_ok), 64'd0);
         check({pfx, "flush_acc"}, 64'(acc), 64'd5);
         check({pfx, "flush_res"}, 64'(result), 64'd1006);
         go(2'b00, 1'b0, W'(6), W'(7));
         check({pfx, "after_flush"}, 64'(result), 64'd42);

         pulses = 0;
         op = 2'b01; sign = 1'b1; en = 1'b1;
         for (int i = 0; i < 3 * (LAT + 1); i++) begin
            a = W'(i * 37 + 5);
            b = W'(200 - i * 29);
            intr = (i == LAT);
            @(negedge clk);
            if (data_ok) pulses++;
            @(posedge clk); #1;
         end
         en = 1'b0; intr = 1'b0;
         for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            if (data_ok) pulses++;
            @(posedge clk); #1;
         end
         check({pfx, "hold_pulses"}, 64'(pulses), 64'd3);

         op = 2'b01; sign = 1'b0; a = W'(9); b = W'(9); en = 1'b1;
         @(posedge clk); #1;
         en = 1'b0;
         repeat (LAT - 2) begin
            @(posedge clk); #1;
         end
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         @(negedge clk);
         check({pfx, "mid_rst_res"}, 64'(result), 64'd0);
         check({pfx, "mid_rst_acc"}, 64'(acc), 64'd0);
         check({pfx, "mid_rst_dok"}, 64'(data_ok), 64'd0);
         check({pfx, "mid_rst_rdy"}, 64'(ready), 64'd1);
         @(posedge clk); #1;

         for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               acc_wdata = {W2{1'b0}} | W2'({$urandom, $urandom});
               acc_we = 1'b1;
            end
            go(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               W'($urandom), W'($urandom));
         end
         done = 1'b1;
      end
   end

   initial begin
      bit fin = 1'b0;
      for (int i = 0; i < 40000; i++) begin
         @(posedge clk);
         if (cfg[0].done && cfg[1].done) begin
            fin = 1'b1;
            break;
         end
      end
      if (!fin) begin
         tests++;
         fails++;
         $display("FAIL timeout: got unfinished expected finished");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
